// File: rtl/spart_bus_fifo_pkg.sv
// spart_pkg: shared types and constants for the SPART bus/FIFO block.
//   tx_state_t    - drain FSM states
//   ADDR_*        - ioaddr register map
//   ST_*          - status register bit positions
//   sat_occ()     - FIFO occupancy saturated to the 3-bit status field
package spart_pkg;

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY} tx_state_t;

  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DBL    = 2'b10;
  localparam logic [1:0] ADDR_DBH    = 2'b11;

  localparam int ST_RDA    = 0;
  localparam int ST_TBR    = 1;
  localparam int ST_OVR    = 2;
  localparam int ST_TXIDLE = 3;
  localparam int ST_TXDROP = 4;

  // Status bits [7:5] report RX occupancy, clamped so deep FIFOs still fit.
  function automatic logic [2:0] sat_occ(input int unsigned n);
    return (n > 7) ? 3'd7 : 3'(n);
  endfunction

endpackage

// File: rtl/spart_bus_fifo_if.sv
// spart_bus_fifo_if: processor-bus control and serializer handshake signals.
//   iocs/iorw/ioaddr         - processor access strobe, direction, register select
//   rx_valid/rx_data         - received character from spart_rx
//   tx_ready/tx_start/tx_data - handshake with spart_tx
//   divisor                  - baud divisor to the rx/tx modules
// The bidirectional databus stays a plain inout port on the top module.
interface spart_bus_fifo_if #(parameter int DATA_W = 8);

  logic              iocs;
  logic              iorw;
  logic [1:0]        ioaddr;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              tx_ready;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic [15:0]       divisor;

  // master: the processor plus the rx/tx peers that drive this block
  modport master (output iocs, iorw, ioaddr, rx_valid, rx_data, tx_ready,
                  input  tx_start, tx_data, divisor);

  // slave: spart_bus_fifo itself
  modport slave  (input  iocs, iorw, ioaddr, rx_valid, rx_data, tx_ready,
                  output tx_start, tx_data, divisor);

endinterface

// File: rtl/spart_bus_fifo_fifo.sv
// spart_fifo: synchronous FIFO, DEPTH entries (power of 2), first-word fall-through.
//   i_push/i_data  - write request and data
//   i_pop          - read request; o_data shows the head combinationally
//   o_full/o_empty - occupancy flags
//   o_count        - number of stored entries, 0..DEPTH
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module spart_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [DATA_W-1:0]        i_data,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_pop;
  logic              w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  // NOTE: storage has no reset; only pointers and count decide what is valid,
  // which keeps the array a plain RAM without a reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;   // wraps modulo DEPTH
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/spart_bus_fifo.sv
// spart_bus_fifo: SPART processor-side register interface with RX/TX FIFOs.
//   clk, rst  - single clock, synchronous active-high reset
//   bus       - spart_bus_fifo_if.slave: iocs/iorw/ioaddr, rx_valid/rx_data,
//               tx_ready/tx_start/tx_data, divisor
//   databus   - bidirectional data, driven here only during reads (iocs & iorw)
// Register map: 00 RX pop / TX push, 01 status, 10 divisor low, 11 divisor high.
module spart_bus_fifo
  import spart_pkg::*;
#(
  parameter int          DATA_W     = 8,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd325
) (
  input  logic              clk,
  input  logic              rst,
  spart_bus_fifo_if.slave   bus,
  inout  wire [DATA_W-1:0]  databus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] w_rx_head, w_tx_head, w_status, w_rd_data;
  logic [CW-1:0]     w_rx_count, w_tx_count;
  logic              w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
  logic              w_rd, w_wr, w_rx_pop, w_tx_push, w_tx_pop;
  logic              w_st_rd, w_rx_ovr_evt, w_tx_drop_evt;

  tx_state_t         r_state;
  logic              r_tx_start;
  logic [DATA_W-1:0] r_tx_data;
  logic [15:0]       r_divisor;
  logic              r_rx_ovr;
  logic              r_tx_drop;

  assign w_rd      = bus.iocs &  bus.iorw;
  assign w_wr      = bus.iocs & ~bus.iorw;
  assign w_st_rd   = w_rd & (bus.ioaddr == ADDR_STATUS);
  assign w_rx_pop  = w_rd & (bus.ioaddr == ADDR_DATA) & ~w_rx_empty;
  assign w_tx_push = w_wr & (bus.ioaddr == ADDR_DATA);
  assign w_tx_pop  = (r_state == IDLE) & ~w_tx_empty & bus.tx_ready;

  // A full FIFO still accepts when the other side drains it in the same cycle.
  assign w_rx_ovr_evt  = bus.rx_valid & w_rx_full & ~w_rx_pop;
  assign w_tx_drop_evt = w_tx_push & w_tx_full & ~w_tx_pop;

  spart_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .i_push(bus.rx_valid), .i_pop(w_rx_pop),
    .i_data(bus.rx_data), .o_data(w_rx_head), .o_full(w_rx_full),
    .o_empty(w_rx_empty), .o_count(w_rx_count)
  );

  spart_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .i_push(w_tx_push), .i_pop(w_tx_pop),
    .i_data(databus), .o_data(w_tx_head), .o_full(w_tx_full),
    .o_empty(w_tx_empty), .o_count(w_tx_count)
  );

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_status            = '0;
    w_status[ST_RDA]    = ~w_rx_empty;
    w_status[ST_TBR]    = ~w_tx_full;
    w_status[ST_OVR]    = r_rx_ovr;
    w_status[ST_TXIDLE] = (w_tx_count == '0) & (r_state == IDLE);
    w_status[ST_TXDROP] = r_tx_drop;
    w_status[7:5]       = sat_occ(w_rx_count);
  end

  always_comb begin
    w_rd_data = '0;
    case (bus.ioaddr)
      ADDR_DATA:   if (!w_rx_empty) w_rd_data = w_rx_head;
      ADDR_STATUS: w_rd_data = w_status;
      ADDR_DBL:    w_rd_data[7:0] = r_divisor[7:0];
      ADDR_DBH:    w_rd_data[7:0] = r_divisor[15:8];
      default:     w_rd_data = '0;
    endcase
  end

  assign databus = w_rd ? w_rd_data : 'z;

  // Divisor and sticky flags; a new event in the same cycle as a status read
  // wins so it is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_divisor <= DIV_RESET;
      r_rx_ovr  <= 1'b0;
      r_tx_drop <= 1'b0;
    end else begin
      if (w_wr && bus.ioaddr == ADDR_DBL) r_divisor[7:0]  <= databus[7:0];
      if (w_wr && bus.ioaddr == ADDR_DBH) r_divisor[15:8] <= databus[7:0];
      if (w_rx_ovr_evt)   r_rx_ovr  <= 1'b1;
      else if (w_st_rd)   r_rx_ovr  <= 1'b0;
      if (w_tx_drop_evt)  r_tx_drop <= 1'b1;
      else if (w_st_rd)   r_tx_drop <= 1'b0;
    end
  end

  // Drain FSM: LAUNCH waits for the serializer to acknowledge by dropping
  // tx_ready, BUSY waits for it to finish, so one character is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        IDLE: if (w_tx_pop) begin
          r_tx_data  <= w_tx_head;
          r_tx_start <= 1'b1;
          r_state    <= LAUNCH;
        end
        LAUNCH:  if (!bus.tx_ready) r_state <= BUSY;
        BUSY:    if (bus.tx_ready)  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.tx_start = r_tx_start;
  assign bus.tx_data  = r_tx_data;
  assign bus.divisor  = r_divisor;

endmodule
